// File: rtl/dac_spi_tx.sv
// dac_spi_tx: shifts {CMD, din} out to an SPI DAC as one 16-bit MSB-first frame.
// SCLK idles low and the DAC samples on its rising edge. SDI only moves at CS
// assertion or on SCLK falling transitions, which gives a full half-period of
// setup and hold around every rising edge.
// CLK_DIV is the SCLK half-period in clk cycles (legal 2..255).
module dac_spi_tx #(
  parameter int          CLK_DIV = 4,
  parameter logic [3:0]  CMD     = 4'h3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tx_enb,
  input  logic        start,
  input  logic [11:0] din,
  output logic        dac_cs_n,
  output logic        dac_sclk,
  output logic        dac_sdi,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT_HI, SHIFT_LO, GAP} state_t;

  localparam logic [7:0] HP_LAST = 8'(CLK_DIV - 1);

  state_t      state, state_n;
  logic [7:0]  hp_cnt, hp_cnt_n;
  logic [4:0]  bit_cnt, bit_cnt_n;
  logic [15:0] shreg, shreg_n;
  logic        cs_n_q, cs_n_n;
  logic        sclk_q, sclk_n;
  logic        sdi_q, sdi_n;
  logic        done_q, done_n;
  logic        hp_last;
  logic [15:0] frame_w;

  assign hp_last = (hp_cnt == HP_LAST);
  assign frame_w = {CMD, din};

  assign dac_cs_n = cs_n_q;
  assign dac_sclk = sclk_q;
  assign dac_sdi  = sdi_q;
  assign done     = done_q;
  // Busy covers the whole frame plus the trailing CS-high gap.
  assign busy     = (state != IDLE);

  // State and registered pin drivers; reset forces the pins idle immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      hp_cnt  <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b0;
      sdi_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_n;
      hp_cnt  <= hp_cnt_n;
      bit_cnt <= bit_cnt_n;
      shreg   <= shreg_n;
      cs_n_q  <= cs_n_n;
      sclk_q  <= sclk_n;
      sdi_q   <= sdi_n;
      done_q  <= done_n;
    end
  end

  // Next-state and next-pin logic; every phase lasts HP_LAST+1 cycles.
  always_comb begin
    state_n   = state;
    hp_cnt_n  = hp_cnt + 8'd1;
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    cs_n_n    = cs_n_q;
    sclk_n    = sclk_q;
    sdi_n     = sdi_q;
    done_n    = 1'b0;

    if (state != IDLE && !tx_enb) begin
      // Abort: drop straight back to idle pins, no done pulse.
      state_n   = IDLE;
      hp_cnt_n  = '0;
      bit_cnt_n = '0;
      cs_n_n    = 1'b1;
      sclk_n    = 1'b0;
      sdi_n     = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          hp_cnt_n = '0;
          if (start && tx_enb) begin
            state_n   = SETUP;
            shreg_n   = frame_w;
            sdi_n     = frame_w[15];
            cs_n_n    = 1'b0;
            bit_cnt_n = 5'd16;
          end
        end
        SETUP: begin
          if (hp_last) begin
            hp_cnt_n = '0;
            state_n  = SHIFT_HI;
            sclk_n   = 1'b1;
          end
        end
        SHIFT_HI: begin
          if (hp_last) begin
            // Falling edge: present the next bit; zeros shift in behind bit 0.
            hp_cnt_n  = '0;
            state_n   = SHIFT_LO;
            sclk_n    = 1'b0;
            bit_cnt_n = bit_cnt - 5'd1;
            shreg_n   = shreg << 1;
            sdi_n     = shreg_n[15];
          end
        end
        SHIFT_LO: begin
          if (hp_last) begin
            hp_cnt_n = '0;
            if (bit_cnt == 5'd0) begin
              // Final low phase doubled as CS hold; close the frame.
              state_n = GAP;
              cs_n_n  = 1'b1;
              done_n  = 1'b1;
            end else begin
              state_n = SHIFT_HI;
              sclk_n  = 1'b1;
            end
          end
        end
        GAP: begin
          if (hp_last) begin
            hp_cnt_n = '0;
            state_n  = IDLE;
          end
        end
        default: begin
          state_n  = IDLE;
          hp_cnt_n = '0;
          cs_n_n   = 1'b1;
          sclk_n   = 1'b0;
          sdi_n    = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dac_spi_tx.sv
// tb_dac_spi_tx: directed vectors for dac_spi_tx at CLK_DIV=4 and CLK_DIV=2.
// Cycle k of a test is the interval after the k-th rising edge; start is
// driven in cycle 0 and the frame's pins first change in cycle 1.
module tb_dac_spi_tx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tx_enb = 1'b1;
  logic        start4 = 1'b0, start2 = 1'b0;
  logic [11:0] din = '0;
  logic        cs4, sclk4, sdi4, busy4, done4;
  logic        cs2, sclk2, sdi2, busy2, done2;
  logic        obs_sel = 1'b0;
  logic        o_cs, o_sclk, o_sdi, o_busy, o_done;

  int checks = 0;
  int errors = 0;

  always #8 clk = ~clk;

  dac_spi_tx #(.CLK_DIV(4), .CMD(4'h3)) dut4 (
    .clk(clk), .rst_n(rst_n), .tx_enb(tx_enb), .start(start4), .din(din),
    .dac_cs_n(cs4), .dac_sclk(sclk4), .dac_sdi(sdi4), .busy(busy4), .done(done4));

  dac_spi_tx #(.CLK_DIV(2), .CMD(4'h3)) dut2 (
    .clk(clk), .rst_n(rst_n), .tx_enb(tx_enb), .start(start2), .din(din),
    .dac_cs_n(cs2), .dac_sclk(sclk2), .dac_sdi(sdi2), .busy(busy2), .done(done2));

  assign o_cs   = obs_sel ? cs2   : cs4;
  assign o_sclk = obs_sel ? sclk2 : sclk4;
  assign o_sdi  = obs_sel ? sdi2  : sdi4;
  assign o_busy = obs_sel ? busy2 : busy4;
  assign o_done = obs_sel ? done2 : done4;

  typedef struct {
    logic        sel;
    logic [11:0] din;
    logic        scr;
    logic [15:0] bits;
    int          first_rise;
    int          last_rise;
    int          cs_last;
    int          done_at;
    int          busy_low;
  } vec_t;

  typedef struct {
    logic [15:0] bits;
    int nrise, first_rise, last_rise, cs_first, cs_last, done_first, ndone, busy_low;
  } obs_t;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Watch the selected DUT from cycle k0 until busy drops (bounded).
  task automatic observe(input logic scr, input int k0, output obs_t r);
    logic prev_sclk;
    r = '{bits: '0, nrise: 0, first_rise: -1, last_rise: -1, cs_first: -1,
          cs_last: -1, done_first: -1, ndone: 0, busy_low: -1};
    prev_sclk = 1'b0;
    for (int k = k0; k < k0 + 300; k++) begin
      @(negedge clk);
      if (o_sclk && !prev_sclk) begin
        r.bits = {r.bits[14:0], o_sdi};
        r.nrise++;
        if (r.first_rise < 0) r.first_rise = k;
        r.last_rise = k;
      end
      prev_sclk = o_sclk;
      if (!o_cs) begin
        if (r.cs_first < 0) r.cs_first = k;
        r.cs_last = k;
      end
      if (o_done) begin
        if (r.done_first < 0) r.done_first = k;
        r.ndone++;
      end
      if (!o_busy) begin
        r.busy_low = k;
        break;
      end
      step();
      if (scr) din = 12'($urandom);
    end
  endtask

  task automatic set_start(input logic sel, input logic v);
    if (sel) start2 = v; else start4 = v;
  endtask

  vec_t vecs[6];
  obs_t r;

  initial begin
    vecs[0] = '{1'b0, 12'hA5C, 1'b0, 16'h3A5C, 5, 125, 132, 133, 137};
    vecs[1] = '{1'b0, 12'h000, 1'b0, 16'h3000, 5, 125, 132, 133, 137};
    vecs[2] = '{1'b0, 12'hFFF, 1'b0, 16'h3FFF, 5, 125, 132, 133, 137};
    vecs[3] = '{1'b0, 12'h50A, 1'b1, 16'h350A, 5, 125, 132, 133, 137};
    vecs[4] = '{1'b1, 12'h001, 1'b0, 16'h3001, 3, 63, 66, 67, 69};
    vecs[5] = '{1'b1, 12'hABC, 1'b0, 16'h3ABC, 3, 63, 66, 67, 69};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cs_n", int'(cs4), 1);
    chk("rst_sclk", int'(sclk4), 0);
    chk("rst_sdi", int'(sdi4), 0);
    chk("rst_busy", int'(busy4), 0);
    chk("rst_done", int'(done4), 0);
    step();
    rst_n = 1'b1;
    repeat (2) step();

    // Table-driven single frames
    foreach (vecs[i]) begin
      obs_sel = vecs[i].sel;
      din = vecs[i].din;
      set_start(vecs[i].sel, 1'b1);
      step();
      set_start(vecs[i].sel, 1'b0);
      if (vecs[i].scr) din = 12'($urandom);
      observe(vecs[i].scr, 1, r);
      chk($sformatf("v%0d_bits", i), int'(r.bits), int'(vecs[i].bits));
      chk($sformatf("v%0d_nrise", i), r.nrise, 16);
      chk($sformatf("v%0d_first_rise", i), r.first_rise, vecs[i].first_rise);
      chk($sformatf("v%0d_last_rise", i), r.last_rise, vecs[i].last_rise);
      chk($sformatf("v%0d_cs_first", i), r.cs_first, 1);
      chk($sformatf("v%0d_cs_last", i), r.cs_last, vecs[i].cs_last);
      chk($sformatf("v%0d_done_at", i), r.done_first, vecs[i].done_at);
      chk($sformatf("v%0d_ndone", i), r.ndone, 1);
      chk($sformatf("v%0d_busy_low", i), r.busy_low, vecs[i].busy_low);
      repeat (3) step();
    end
    obs_sel = 1'b0;

    // Back-to-back with start held high: second frame accepted in cycle 137
    din = 12'h000;
    start4 = 1'b1;
    step();
    for (int k = 1; k <= 137; k++) begin
      if (k == 1) din = 12'hFFF;
      @(negedge clk);
      if (k == 136) chk("b2b_busy_136", int'(busy4), 1);
      if (k == 137) begin
        chk("b2b_busy_137", int'(busy4), 0);
        chk("b2b_cs_137", int'(cs4), 1);
      end
      step();
    end
    start4 = 1'b0;
    observe(1'b0, 138, r);
    chk("b2b_cs_first", r.cs_first, 138);
    chk("b2b_bits", int'(r.bits), int'(16'h3FFF));
    chk("b2b_done_at", r.done_first, 270);
    chk("b2b_busy_low", r.busy_low, 274);
    repeat (3) step();

    // Ignored start pulses while busy
    begin
      int nd;
      int idle_bad;
      nd = 0;
      idle_bad = 0;
      din = 12'h5A5;
      start4 = 1'b1;
      step();
      for (int k = 1; k <= 150; k++) begin
        start4 = (k == 50 || k == 136);
        @(negedge clk);
        if (done4) nd++;
        if (k >= 137 && (busy4 || !cs4 || sclk4)) idle_bad++;
        step();
      end
      start4 = 1'b0;
      chk("ign_ndone", nd, 1);
      chk("ign_idle_bad", idle_bad, 0);
    end
    repeat (2) step();

    // Abort by tx_enb in cycle 60
    begin
      int nd;
      int act;
      nd = 0;
      act = 0;
      din = 12'hFFF;
      start4 = 1'b1;
      step();
      start4 = 1'b0;
      for (int k = 1; k <= 70; k++) begin
        if (k == 60) tx_enb = 1'b0;
        @(negedge clk);
        if (done4) nd++;
        if (k == 59) chk("abt_busy_59", int'(busy4), 1);
        if (k == 61) begin
          chk("abt_cs", int'(cs4), 1);
          chk("abt_sclk", int'(sclk4), 0);
          chk("abt_sdi", int'(sdi4), 0);
          chk("abt_busy", int'(busy4), 0);
        end
        step();
      end
      chk("abt_ndone", nd, 0);
      // tx_enb still low: start must do nothing
      start4 = 1'b1;
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        if (busy4 || !cs4 || sclk4) act++;
        step();
      end
      start4 = 1'b0;
      chk("dis_activity", act, 0);
      tx_enb = 1'b1;
    end
    repeat (2) step();

    // Asynchronous reset in cycle 40 of a frame
    begin
      int act;
      act = 0;
      din = 12'hFFF;
      start4 = 1'b1;
      step();
      start4 = 1'b0;
      for (int k = 1; k < 40; k++) step();
      chk("prerst_sclk", int'(sclk4), 1);
      rst_n = 1'b0;
      #2;
      chk("arst_cs", int'(cs4), 1);
      chk("arst_sclk", int'(sclk4), 0);
      chk("arst_sdi", int'(sdi4), 0);
      chk("arst_busy", int'(busy4), 0);
      repeat (3) step();
      rst_n = 1'b1;
      for (int k = 0; k < 40; k++) begin
        @(negedge clk);
        if (busy4 || !cs4 || sclk4 || done4) act++;
        step();
      end
      chk("postrst_activity", act, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
